// File: rtl/gpo_pkg.sv
// ---------------------------------------------------------------------------
// gpo_pkg : register addresses, register enum and constants for gpo_ctrl
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package gpo_pkg;

  localparam logic [2:0] GPO_A_DATA  = 3'd0;
  localparam logic [2:0] GPO_A_SET   = 3'd1;
  localparam logic [2:0] GPO_A_CLR   = 3'd2;
  localparam logic [2:0] GPO_A_TGL   = 3'd3;
  localparam logic [2:0] GPO_A_PULSE = 3'd4;
  localparam logic [2:0] GPO_A_PLEN  = 3'd5;
  localparam logic [2:0] GPO_A_BEN   = 3'd6;
  localparam logic [2:0] GPO_A_BDIV  = 3'd7;

  localparam int BLINK_DW = 24;

  typedef enum logic [2:0] {
    REG_DATA  = GPO_A_DATA,
    REG_SET   = GPO_A_SET,
    REG_CLR   = GPO_A_CLR,
    REG_TGL   = GPO_A_TGL,
    REG_PULSE = GPO_A_PULSE,
    REG_PLEN  = GPO_A_PLEN,
    REG_BEN   = GPO_A_BEN,
    REG_BDIV  = GPO_A_BDIV
  } gpo_reg_e;

endpackage

`default_nettype wire

// File: rtl/gpo_pulse_timer.sv
// ---------------------------------------------------------------------------
// gpo_pulse_timer : one-shot pulse mask held high for a loaded cycle count
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module gpo_pulse_timer #(
  parameter int W  = 8,
  parameter int PW = 16
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          start,
  input  logic [W-1:0]  mask,
  input  logic [PW-1:0] len,
  output logic [W-1:0]  pulse_mask,
  output logic          busy
);

  logic [W-1:0]  mask_q, mask_d;
  logic [PW-1:0] cnt_q, cnt_d;

  always_comb begin
    mask_d = mask_q;
    cnt_d  = cnt_q;
    // A zero length or empty mask leaves any running pulse untouched
    if (start && (len != '0) && (mask != '0)) begin
      mask_d = mask;
      cnt_d  = len;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - PW'(1);
      if (cnt_q == PW'(1)) begin
        mask_d = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      mask_q <= '0;
      cnt_q  <= '0;
    end else begin
      mask_q <= mask_d;
      cnt_q  <= cnt_d;
    end
  end

  assign pulse_mask = mask_q;
  assign busy       = (cnt_q != '0);

endmodule

`default_nettype wire

// File: rtl/gpo_ctrl.sv
// ---------------------------------------------------------------------------
// gpo_ctrl : GPO register with SET/CLR/TGL, one-shot pulses, optional blink
// Optional feature: GPO_BLINK_EN adds BLINK_EN/BLINK_DIV. Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module gpo_ctrl
  import gpo_pkg::*;
#(
  parameter int W  = 8,
  parameter int PW = 16
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         cs,
  input  logic         write,
  input  logic         read,
  input  logic [4:0]   addr,
  input  logic [31:0]  wr_data,
  output logic [31:0]  rd_data,
  output logic [W-1:0] dout
);

  logic          wr_en;
  logic          addr_ok;
  gpo_reg_e      reg_sel;
  logic [W-1:0]  wdat;
  logic [W-1:0]  data_q, data_d;
  logic [PW-1:0] plen_q, plen_d;
  logic          pulse_start;
  logic [W-1:0]  pulse_mask;
  logic          pulse_busy;

  assign wr_en   = cs & write;
  assign addr_ok = (addr[4:3] == 2'b00);
  assign reg_sel = gpo_reg_e'(addr[2:0]);
  assign wdat    = wr_data[W-1:0];

  always_comb begin
    data_d = data_q;
    plen_d = plen_q;
    if (wr_en && addr_ok) begin
      case (reg_sel)
        REG_DATA: data_d = wdat;
        REG_SET:  data_d = data_q | wdat;
        REG_CLR:  data_d = data_q & ~wdat;
        REG_TGL:  data_d = data_q ^ wdat;
        REG_PLEN: plen_d = wr_data[PW-1:0];
        default:  ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      data_q <= '0;
      plen_q <= '0;
    end else begin
      data_q <= data_d;
      plen_q <= plen_d;
    end
  end

  assign pulse_start = wr_en && addr_ok && (reg_sel == REG_PULSE);

  gpo_pulse_timer #(
    .W  (W),
    .PW (PW)
  ) u_pulse (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (pulse_start),
    .mask       (wdat),
    .len        (plen_q),
    .pulse_mask (pulse_mask),
    .busy       (pulse_busy)
  );

`ifdef GPO_BLINK_EN
  logic [W-1:0]        ben_q, ben_d;
  logic [BLINK_DW-1:0] bdiv_q, bdiv_d;
  logic [BLINK_DW-1:0] presc_q, presc_d;
  logic                phase_q, phase_d;

  always_comb begin
    ben_d   = ben_q;
    bdiv_d  = bdiv_q;
    presc_d = presc_q + BLINK_DW'(1);
    phase_d = phase_q;
    if (presc_q == bdiv_q) begin
      presc_d = '0;
      phase_d = ~phase_q;
    end
    if (wr_en && addr_ok && (reg_sel == REG_BEN)) begin
      ben_d = wdat;
    end
    // Reprogramming the divider restarts the blink from a known phase
    if (wr_en && addr_ok && (reg_sel == REG_BDIV)) begin
      bdiv_d  = wr_data[BLINK_DW-1:0];
      presc_d = '0;
      phase_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ben_q   <= '0;
      bdiv_q  <= '0;
      presc_q <= '0;
      phase_q <= 1'b0;
    end else begin
      ben_q   <= ben_d;
      bdiv_q  <= bdiv_d;
      presc_q <= presc_d;
      phase_q <= phase_d;
    end
  end

  assign dout = (data_q & ~ben_q) | (data_q & ben_q & {W{phase_q}}) | pulse_mask;
`else
  assign dout = data_q | pulse_mask;
`endif

  always_comb begin
    rd_data = '0;
    if (addr_ok) begin
      case (reg_sel)
        REG_DATA, REG_SET, REG_CLR, REG_TGL: rd_data[W-1:0] = data_q;
        REG_PULSE: rd_data[W-1:0]  = pulse_mask;
        REG_PLEN:  rd_data[PW-1:0] = plen_q;
`ifdef GPO_BLINK_EN
        REG_BEN:   rd_data[W-1:0]        = ben_q;
        REG_BDIV:  rd_data[BLINK_DW-1:0] = bdiv_q;
`endif
        default:   ;
      endcase
    end
  end

  logic unused_ok;
  assign unused_ok = ^{read, wr_data, pulse_busy};

endmodule

`default_nettype wire

// File: tb/tb_gpo_ctrl.sv
// ---------------------------------------------------------------------------
// tb_gpo_ctrl : directed table plus hand sequences for gpo_ctrl
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module tb_gpo_ctrl;

  localparam int W  = 8;
  localparam int PW = 16;
  localparam int NV = 17;

  logic        clk     = 1'b0;
  logic        reset_n = 1'b0;
  logic        cs      = 1'b0;
  logic        write   = 1'b0;
  logic        read    = 1'b0;
  logic [4:0]  addr    = '0;
  logic [31:0] wr_data = '0;
  logic [31:0] rd_data;
  logic [W-1:0] dout;

  int n_pass  = 0;
  int n_total = 0;

  typedef struct {
    logic        is_wr;
    logic [4:0]  a;
    logic [31:0] d;
    logic [7:0]  exp_dout;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t vecs [NV];

  gpo_ctrl #(.W(W), .PW(PW)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .cs      (cs),
    .write   (write),
    .read    (read),
    .addr    (addr),
    .wr_data (wr_data),
    .rd_data (rd_data),
    .dout    (dout)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Strobe one write; returns just after the edge that commits it
  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    @(negedge clk);
    cs      = 1'b1;
    write   = 1'b1;
    addr    = a;
    wr_data = d;
    @(posedge clk);
    #1;
    cs    = 1'b0;
    write = 1'b0;
  endtask

  task automatic rd_chk(input string name, input logic [4:0] a, input logic [31:0] exp);
    cs   = 1'b1;
    read = 1'b1;
    addr = a;
    #1;
    check(name, rd_data, exp);
    cs   = 1'b0;
    read = 1'b0;
  endtask

  task automatic dout_chk(input string name, input logic [7:0] exp);
    check(name, 32'(dout), 32'(exp));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected $finish");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0]  = '{1'b1, 5'd0,  32'h0000_00A5, 8'hA5, 32'h0};
    vecs[1]  = '{1'b0, 5'd0,  32'h0,         8'hA5, 32'h0000_00A5};
    vecs[2]  = '{1'b1, 5'd1,  32'h0000_000F, 8'hAF, 32'h0};
    vecs[3]  = '{1'b0, 5'd1,  32'h0,         8'hAF, 32'h0000_00AF};
    vecs[4]  = '{1'b1, 5'd2,  32'h0000_0081, 8'h2E, 32'h0};
    vecs[5]  = '{1'b0, 5'd2,  32'h0,         8'h2E, 32'h0000_002E};
    vecs[6]  = '{1'b1, 5'd3,  32'h0000_00FF, 8'hD1, 32'h0};
    vecs[7]  = '{1'b0, 5'd3,  32'h0,         8'hD1, 32'h0000_00D1};
    vecs[8]  = '{1'b0, 5'd0,  32'h0,         8'hD1, 32'h0000_00D1};
    vecs[9]  = '{1'b1, 5'd5,  32'hABCD_0007, 8'hD1, 32'h0};
    vecs[10] = '{1'b0, 5'd5,  32'h0,         8'hD1, 32'h0000_0007};
    vecs[11] = '{1'b1, 5'd8,  32'h0000_0000, 8'hD1, 32'h0};
    vecs[12] = '{1'b0, 5'd8,  32'h0,         8'hD1, 32'h0};
    vecs[13] = '{1'b0, 5'd12, 32'h0,         8'hD1, 32'h0};
    vecs[14] = '{1'b1, 5'd0,  32'hFFFF_FF3C, 8'h3C, 32'h0};
    vecs[15] = '{1'b0, 5'd0,  32'h0,         8'h3C, 32'h0000_003C};
    vecs[16] = '{1'b0, 5'd4,  32'h0,         8'h3C, 32'h0};

    reset_n = 1'b0;
    repeat (3) tick();
    dout_chk("reset dout", 8'h00);
    rd_chk("reset rd data", 5'd0, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    tick();

    for (int i = 0; i < NV; i++) begin
      if (vecs[i].is_wr) begin
        wr(vecs[i].a, vecs[i].d);
      end else begin
        rd_chk($sformatf("vec%0d rd", i), vecs[i].a, vecs[i].exp_rd);
      end
      dout_chk($sformatf("vec%0d dout", i), vecs[i].exp_dout);
    end

    // Reset clears everything, including a programmed pulse length
    wr(5'd5, 32'd3);
    wr(5'd0, 32'hFF);
    dout_chk("pre-reset dout", 8'hFF);
    @(negedge clk);
    reset_n = 1'b0;
    tick();
    dout_chk("in-reset dout", 8'h00);
    tick();
    for (int a = 0; a < 8; a++) rd_chk($sformatf("reset rd a%0d", a), 5'(a), 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    tick();
    dout_chk("post-reset dout", 8'h00);

    // Basic pulse, length 3
    wr(5'd5, 32'd3);
    wr(5'd4, 32'h01);
    dout_chk("pulse c1", 8'h01);
    rd_chk("pulse rd active", 5'd4, 32'h01);
    tick(); dout_chk("pulse c2", 8'h01);
    tick(); dout_chk("pulse c3", 8'h01);
    tick(); dout_chk("pulse end", 8'h00);
    rd_chk("pulse rd done", 5'd4, 32'h0);

    // Restart replaces mask and reloads the count
    wr(5'd5, 32'd4);
    wr(5'd4, 32'h02);
    dout_chk("rst c1", 8'h02);
    tick(); dout_chk("rst c2", 8'h02);
    wr(5'd4, 32'h04);
    dout_chk("rst new c1", 8'h04);
    for (int k = 2; k <= 4; k++) begin
      tick(); dout_chk($sformatf("rst new c%0d", k), 8'h04);
    end
    tick(); dout_chk("rst end", 8'h00);

    // Zero length is ignored
    wr(5'd5, 32'd0);
    wr(5'd4, 32'h08);
    dout_chk("plen0 dout", 8'h00);
    rd_chk("plen0 rd", 5'd4, 32'h0);

    // Empty mask during an active pulse leaves it running
    wr(5'd5, 32'd3);
    wr(5'd4, 32'h01);
    dout_chk("mask0 c1", 8'h01);
    wr(5'd4, 32'h00);
    dout_chk("mask0 c2", 8'h01);
    tick(); dout_chk("mask0 c3", 8'h01);
    tick(); dout_chk("mask0 end", 8'h00);

    // PLEN write mid-pulse only affects the next pulse
    wr(5'd5, 32'd2);
    wr(5'd4, 32'h01);
    dout_chk("plen mid c1", 8'h01);
    wr(5'd5, 32'd5);
    dout_chk("plen mid c2", 8'h01);
    tick(); dout_chk("plen mid end", 8'h00);
    rd_chk("plen readback", 5'd5, 32'd5);

    // DATA write on the expiry edge
    wr(5'd4, 32'h01);
    repeat (4) tick();
    dout_chk("expiry c5", 8'h01);
    wr(5'd0, 32'h80);
    dout_chk("expiry data", 8'h80);

    // Pulse ORs over data
    wr(5'd0, 32'h0F);
    wr(5'd5, 32'd1);
    wr(5'd4, 32'hF0);
    dout_chk("or pulse", 8'hFF);
    tick(); dout_chk("or after", 8'h0F);

    // Reset mid-pulse aborts it for good
    wr(5'd0, 32'h00);
    wr(5'd5, 32'd100);
    wr(5'd4, 32'hF0);
    repeat (8) tick();
    dout_chk("long pulse c9", 8'hF0);
    @(negedge clk);
    reset_n = 1'b0;
    tick();
    dout_chk("abort dout", 8'h00);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (5) tick();
    dout_chk("abort after", 8'h00);
    rd_chk("abort rd pulse", 5'd4, 32'h0);
    rd_chk("abort rd plen", 5'd5, 32'h0);

`ifdef GPO_BLINK_EN
    wr(5'd0, 32'h03);
    wr(5'd6, 32'h01);
    wr(5'd7, 32'd4);
    for (int k = 0; k < 15; k++) begin
      dout_chk($sformatf("blink k%0d", k), (((k / 5) % 2) == 1) ? 8'h03 : 8'h02);
      tick();
    end
    rd_chk("blink rd en", 5'd6, 32'h01);
    rd_chk("blink rd div", 5'd7, 32'd4);
`else
    wr(5'd0, 32'h5A);
    wr(5'd6, 32'hFF);
    wr(5'd7, 32'd1);
    repeat (3) tick();
    dout_chk("no blink dout", 8'h5A);
    rd_chk("no blink rd 6", 5'd6, 32'h0);
    rd_chk("no blink rd 7", 5'd7, 32'h0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
